pam4_symbol_mapper: RTL and testbench

- Upstream stage of the modulation pipe.
- Accepts a 32-bit data word on start and serializes it MSB-first into 16 two-bit Gray-coded PAM-4 symbols.
- Produces one mapped amplitude word per symbol on array_ref_m; this is the value the else-branch calculation stage delays into segment_0.
- Uses a valid/ready handshake and busy/done status so the pipe controller can sequence words.

---
 rtl/pam4_symbol_mapper_if.sv | 33 +++
 rtl/pam4_symbol_mapper.sv | 131 +++++++++++++
 tb/tb_pam4_symbol_mapper.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pam4_symbol_mapper_if.sv
`default_nettype none
// ============================================================================
//  Module   : pam4_symbol_mapper_if
//  Brief    : Handshake/status bundle between the pipe controller and the
//             PAM-4 symbol mapper.
//  Revision : 1.0 - initial release
// ============================================================================
interface pam4_symbol_mapper_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic [DATA_W-1:0] input_bit;
   logic [DATA_W-1:0] zero;
   logic [DATA_W-1:0] amp;
   logic              ready;
   logic [DATA_W-1:0] array_ref_m;
   logic              valid;
   logic              busy;
   logic              done;

   // Controller / downstream side: supplies words and accepts symbols.
   modport master (
      output start, input_bit, zero, amp, ready,
      input  array_ref_m, valid, busy, done
   );

   // Mapper side.
   modport slave (
      input  start, input_bit, zero, amp, ready,
      output array_ref_m, valid, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/pam4_symbol_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : pam4_symbol_mapper
//  Brief    : Serialises a data word MSB-first into Gray-coded PAM-4 symbols
//             and maps each one to zero + L*amp, L in {-3,-1,+1,+3}.
//             BITS_PER_SYM must be 2; other values are not supported.
//  Revision : 1.0 - initial release
// ============================================================================
module pam4_symbol_mapper #(
   parameter int DATA_W       = 32,
   parameter int BITS_PER_SYM = 2,
   parameter int NUM_SYM      = DATA_W / BITS_PER_SYM
) (
   input  wire logic             clk,
   input  wire logic             reset,
   pam4_symbol_mapper_if.slave   bus
);

   localparam int CNT_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SYM - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EMIT   = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] zero_q, zero_d;
   logic [DATA_W-1:0] amp_q, amp_d;
   logic [DATA_W-1:0] ref_q, ref_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;

   logic [DATA_W-1:0] shift_next;

   // Gray symbol to amplitude: 00->-3, 01->-1, 11->+1, 10->+3, all modulo 2^DATA_W.
   // Negative levels subtract the product, i.e. add its two's-complement negation.
   function automatic logic [DATA_W-1:0] map_sym(
      input logic [1:0]        sym,
      input logic [DATA_W-1:0] base,
      input logic [DATA_W-1:0] step
   );
      logic [DATA_W-1:0] step3;
      step3 = (step << 1) + step;
      case (sym)
         2'b00:   map_sym = base - step3;
         2'b01:   map_sym = base - step;
         2'b11:   map_sym = base + step;
         default: map_sym = base + step3;
      endcase
   endfunction

   assign shift_next = shift_q << BITS_PER_SYM;

   // Next-state logic: load on start in IDLE, advance one symbol per handshake.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      amp_d   = amp_q;
      ref_d   = ref_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               shift_d = bus.input_bit;
               zero_d  = bus.zero;
               amp_d   = bus.amp;
               cnt_d   = CNT_LAST;
               ref_d   = map_sym(bus.input_bit[DATA_W-1 -: 2], bus.zero, bus.amp);
               valid_d = 1'b1;
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (valid_q && bus.ready) begin
               if (cnt_q != '0) begin
                  shift_d = shift_next;
                  cnt_d   = cnt_q - 1'b1;
                  ref_d   = map_sym(shift_next[DATA_W-1 -: 2], zero_q, amp_q);
               end else begin
                  // Last symbol taken: drop valid and raise done for the FINISH cycle.
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_FINISH;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset abandons any word in flight without a done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         zero_q  <= '0;
         amp_q   <= '0;
         ref_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         amp_q   <= amp_d;
         ref_q   <= ref_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign bus.array_ref_m = ref_q;
   assign bus.valid       = valid_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pam4_symbol_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pam4_symbol_mapper
//  Brief    : Directed self-checking bench for pam4_symbol_mapper.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pam4_symbol_mapper;

   localparam int DATA_W = 32;

   logic        clk;
   logic        reset;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          valid_edges = 0;
   logic [31:0] exp_sym [16];

   pam4_symbol_mapper_if #(.DATA_W(DATA_W)) bus ();

   pam4_symbol_mapper #(
      .DATA_W       (DATA_W),
      .BITS_PER_SYM (2),
      .NUM_SYM      (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count edges at which the DUT presents valid (pre-edge value).
   always @(posedge clk) begin
      if (bus.valid === 1'b1) valid_edges++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_basic_exp();
      exp_sym[0] = 32'hFFFF_FED4;   // 00 -> -300
      exp_sym[1] = 32'hFFFF_FF9C;   // 01 -> -100
      exp_sym[2] = 32'h0000_0064;   // 11 -> +100
      exp_sym[3] = 32'h0000_012C;   // 10 -> +300
      for (int i = 4; i < 16; i++) exp_sym[i] = 32'hFFFF_FED4;
   endtask

   // Called on a negedge; drives start immediately and returns on the
   // negedge of the IDLE cycle that follows the done pulse.
   task automatic run_word(input logic [31:0] data, input logic [31:0] z, input logic [31:0] a,
                           input int stall_sym, input int stall_len, input int busy_start_sym);
      bus.start     = 1'b1;
      bus.input_bit = data;
      bus.zero      = z;
      bus.amp       = a;
      bus.ready     = 1'b1;
      valid_edges   = 0;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.input_bit = ~data;
      bus.zero      = 32'h1234_5678;
      bus.amp       = 32'h0BAD_F00D;
      for (int s = 0; s < 16; s++) begin
         check_eq($sformatf("sym%0d", s), bus.array_ref_m, exp_sym[s]);
         check_eq($sformatf("valid%0d", s), {31'd0, bus.valid}, 32'd1);
         check_eq($sformatf("busy%0d", s), {31'd0, bus.busy}, 32'd1);
         check_eq($sformatf("done%0d", s), {31'd0, bus.done}, 32'd0);
         if (s == stall_sym) begin
            for (int k = 0; k < stall_len; k++) begin
               bus.ready = 1'b0;
               @(negedge clk);
               check_eq($sformatf("hold%0d_%0d", s, k), bus.array_ref_m, exp_sym[s]);
               check_eq($sformatf("hold_valid%0d_%0d", s, k), {31'd0, bus.valid}, 32'd1);
            end
         end
         bus.ready = 1'b1;
         if (s == busy_start_sym) begin
            bus.start     = 1'b1;
            bus.input_bit = 32'hFFFF_FFFF;
         end
         @(negedge clk);
         bus.start = 1'b0;
      end
      check_eq("finish_valid", {31'd0, bus.valid}, 32'd0);
      check_eq("finish_done", {31'd0, bus.done}, 32'd1);
      check_eq("finish_busy", {31'd0, bus.busy}, 32'd1);
      check_eq("valid_cycles", valid_edges, 32'(16 + stall_len));
      @(negedge clk);
      check_eq("idle_done", {31'd0, bus.done}, 32'd0);
      check_eq("idle_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("idle_valid", {31'd0, bus.valid}, 32'd0);
   endtask

   initial begin
      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.input_bit = '0;
      bus.zero      = '0;
      bus.amp       = '0;
      bus.ready     = 1'b1;
      @(negedge clk);
      check_eq("rst_ref", bus.array_ref_m, 32'd0);
      check_eq("rst_valid", {31'd0, bus.valid}, 32'd0);
      check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("rst_done", {31'd0, bus.done}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Basic map
      set_basic_exp();
      run_word(32'h1E00_0000, 32'd0, 32'd100, -1, 0, -1);

      // Offset and wrap: 0x7FFFFFFF + 3 wraps to 0x80000002
      for (int i = 0; i < 16; i++) exp_sym[i] = 32'h8000_0002;
      run_word(32'hAAAA_AAAA, 32'h7FFF_FFFF, 32'd1, -1, 0, -1);

      // Backpressure on symbol 2 for 3 cycles
      set_basic_exp();
      run_word(32'h1E00_0000, 32'd0, 32'd100, 2, 3, -1);

      // Start while busy during symbol 5 is ignored
      run_word(32'h1E00_0000, 32'd0, 32'd100, -1, 0, 5);

      // Start in the cycle right after done is accepted
      run_word(32'h1E00_0000, 32'd0, 32'd100, -1, 0, -1);

      // Reset mid-word at symbol 7
      bus.start     = 1'b1;
      bus.input_bit = 32'h1E00_0000;
      bus.zero      = 32'd0;
      bus.amp       = 32'd100;
      bus.ready     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      check_eq("pre_rst_sym7", bus.array_ref_m, exp_sym[7]);
      #2 reset = 1'b0;
      #1;
      check_eq("mid_rst_ref", bus.array_ref_m, 32'd0);
      check_eq("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
      check_eq("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("mid_rst_done", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("post_rst_done", {31'd0, bus.done}, 32'd0);
      check_eq("post_rst_busy", {31'd0, bus.busy}, 32'd0);
      for (int i = 0; i < 16; i++) exp_sym[i] = 32'hFFFF_FFF6;   // 01 -> -10
      run_word(32'h5555_5555, 32'd0, 32'd10, -1, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
